gpu_block_axi_slave: RTL and testbench

//  AXI4 (full) burst responder for the GPU block/tile store; the slave end of the S_BLOCK_AXI master traffic.

---
 rtl/gpu_block_axi_pkg.sv | 40 ++++
 rtl/gpu_block_axi_burst_addr.sv | 48 ++++
 rtl/gpu_block_axi_slave.sv | 177 +++++++++++++++++
 tb/tb_gpu_block_axi_slave.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_block_axi_pkg.sv
// rtl/gpu_block_axi_pkg.sv - burst/response encodings, FSM states and burst address stepping for the GPU block AXI slave
package gpu_block_axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Beats are always one 32-bit word; WRAP with an illegal length degrades to INCR.
   function automatic logic [31:0] next_burst_addr(input logic [31:0] addr,
                                                   input logic [7:0]  len,
                                                   input logic [1:0]  burst);
      logic [31:0] mask;
      logic [31:0] next;
      mask = {22'd0, len, 2'b11};
      next = addr + 32'd4;
      if (burst == BURST_FIXED)
         next = addr;
      else if (burst == BURST_WRAP &&
               (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         next = (addr & ~mask) | (next & mask);
      return next;
   endfunction

endpackage

// File: rtl/gpu_block_axi_burst_addr.sv
// rtl/gpu_block_axi_burst_addr.sv - registered burst address counter with a last-beat flag
module gpu_block_axi_burst_addr
   import gpu_block_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  load,
   input  logic                  advance,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [7:0]            load_len,
   input  logic [1:0]            load_burst,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  last
);

   logic [7:0]  len;
   logic [7:0]  remaining;
   logic [1:0]  burst;
   logic [31:0] next_full;
   logic        unused_next_hi;

   assign next_full      = next_burst_addr({{(32-ADDR_WIDTH){1'b0}}, addr}, len, burst);
   assign next_addr      = next_full[ADDR_WIDTH-1:0];
   assign unused_next_hi = ^next_full[31:ADDR_WIDTH];
   assign last           = (remaining == 8'd0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr      <= '0;
         len       <= '0;
         remaining <= '0;
         burst     <= BURST_INCR;
      end else if (load) begin
         addr      <= load_addr;
         len       <= load_len;
         remaining <= load_len;
         burst     <= load_burst;
      end else if (advance) begin
         addr <= next_addr;
         if (!last)
            remaining <= remaining - 8'd1;
      end
   end

endmodule

// File: rtl/gpu_block_axi_slave.sv
// rtl/gpu_block_axi_slave.sv - AXI4 burst slave over a word store plus GPU read port; GPU_BLOCK_AXI_SLVERR_EN enables range errors
module gpu_block_axi_slave
   import gpu_block_axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int ID_WIDTH   = 1,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [ID_WIDTH-1:0]          AWID,
   input  logic [ADDR_WIDTH-1:0]        AWADDR,
   input  logic [7:0]                   AWLEN,
   input  logic [2:0]                   AWSIZE,
   input  logic [1:0]                   AWBURST,
   input  logic                         AWVALID,
   output logic                         AWREADY,
   input  logic [DATA_WIDTH-1:0]        WDATA,
   input  logic [DATA_WIDTH/8-1:0]      WSTRB,
   input  logic                         WLAST,
   input  logic                         WVALID,
   output logic                         WREADY,
   output logic [ID_WIDTH-1:0]          BID,
   output logic [1:0]                   BRESP,
   output logic                         BVALID,
   input  logic                         BREADY,
   input  logic [ID_WIDTH-1:0]          ARID,
   input  logic [ADDR_WIDTH-1:0]        ARADDR,
   input  logic [7:0]                   ARLEN,
   input  logic [2:0]                   ARSIZE,
   input  logic [1:0]                   ARBURST,
   input  logic                         ARVALID,
   output logic                         ARREADY,
   output logic [ID_WIDTH-1:0]          RID,
   output logic [DATA_WIDTH-1:0]        RDATA,
   output logic [1:0]                   RRESP,
   output logic                         RLAST,
   output logic                         RVALID,
   input  logic                         RREADY,
   input  logic [$clog2(MEM_DEPTH)-1:0] gpu_rd_addr,
   output logic [DATA_WIDTH-1:0]        gpu_rd_data
);

   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic      out_en;
   logic      aw_hs, w_hs, b_hs, ar_hs, r_hs, r_adv, rd_load, mem_we;
   logic      wr_last, rd_last;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_next_addr, rd_addr, rd_next_addr, rd_src;
   logic      unused_ok;

   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign b_hs    = BVALID & BREADY;
   assign ar_hs   = ARVALID & ARREADY;
   assign r_hs    = RVALID & RREADY;
   assign r_adv   = r_hs & ~rd_last;
   assign rd_load = ar_hs | r_adv;
   assign rd_src  = ar_hs ? ARADDR : rd_next_addr;

   assign unused_ok = ^{AWSIZE, ARSIZE, WLAST, wr_addr, wr_next_addr, rd_addr, rd_src};

   gpu_block_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
      .clk(ACLK), .resetn(ARESETN), .load(aw_hs), .advance(w_hs),
      .load_addr(AWADDR), .load_len(AWLEN), .load_burst(AWBURST),
      .addr(wr_addr), .next_addr(wr_next_addr), .last(wr_last)
   );

   gpu_block_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
      .clk(ACLK), .resetn(ARESETN), .load(ar_hs), .advance(r_adv),
      .load_addr(ARADDR), .load_len(ARLEN), .load_burst(ARBURST),
      .addr(rd_addr), .next_addr(rd_next_addr), .last(rd_last)
   );

   // Holds the ready outputs low through reset and for the release edge itself.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         out_en   <= 1'b0;
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         out_en   <= 1'b1;
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE:  if (aw_hs) wr_next = W_DATA;
         W_DATA:  if (w_hs && wr_last) wr_next = W_RESP;
         W_RESP:  if (b_hs) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs) rd_next = R_DATA;
         R_DATA:  if (r_hs && rd_last) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      AWREADY = out_en && (wr_state == W_IDLE);
      WREADY  = out_en && (wr_state == W_DATA);
      BVALID  = out_en && (wr_state == W_RESP);
      ARREADY = out_en && (rd_state == R_IDLE);
      RVALID  = out_en && (rd_state == R_DATA);
      RLAST   = RVALID && rd_last;
   end

`ifdef GPU_BLOCK_AXI_SLVERR_EN
   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} >= (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
   endfunction

   logic wr_oor, rd_oor, wr_err;
   assign wr_oor = out_of_range(wr_addr);
   assign rd_oor = out_of_range(rd_src);
   assign mem_we = w_hs && ARESETN && !wr_oor;
   assign BRESP  = (BVALID && wr_err) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge ACLK) begin
      if (!ARESETN)
         wr_err <= 1'b0;
      else if (aw_hs)
         wr_err <= 1'b0;
      else if (w_hs && wr_oor)
         wr_err <= 1'b1;
   end
`else
   assign mem_we = w_hs && ARESETN;
   assign BRESP  = RESP_OKAY;
`endif

   // Non-blocking update: any same-edge read of this word sees the old value.
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++)
            if (WSTRB[b])
               mem[wr_addr[IDX_W+1:2]][8*b +: 8] <= WDATA[8*b +: 8];
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         BID         <= '0;
         RID         <= '0;
         RDATA       <= '0;
         RRESP       <= RESP_OKAY;
         gpu_rd_data <= '0;
      end else begin
         gpu_rd_data <= mem[gpu_rd_addr];
         if (aw_hs)
            BID <= AWID;
         if (ar_hs)
            RID <= ARID;
         if (rd_load) begin
`ifdef GPU_BLOCK_AXI_SLVERR_EN
            RDATA <= rd_oor ? '0 : mem[rd_src[IDX_W+1:2]];
            RRESP <= rd_oor ? RESP_SLVERR : RESP_OKAY;
`else
            RDATA <= mem[rd_src[IDX_W+1:2]];
            RRESP <= RESP_OKAY;
`endif
         end
      end
   end

endmodule

// File: tb/tb_gpu_block_axi_slave.sv
// tb/tb_gpu_block_axi_slave.sv - directed self-checking bench for gpu_block_axi_slave
module tb_gpu_block_axi_slave;
   import gpu_block_axi_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [0:0]  AWID = '0, ARID = '0, BID, RID;
   logic [11:0] AWADDR = '0, ARADDR = '0;
   logic [7:0]  AWLEN = '0, ARLEN = '0;
   logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
   logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
   logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
   logic        ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;
   logic [31:0] WDATA = '0, RDATA, gpu_rd_data;
   logic [3:0]  WSTRB = '0;
   logic [7:0]  gpu_rd_addr = '0;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] wr_data [16];
   logic [31:0] rd_data [16];
   logic        rd_last [16];
   logic [1:0]  rd_resp [16];
   logic [1:0]  last_bresp;
   logic [0:0]  last_bid, last_rid;
   logic        first_rvalid;

   gpu_block_axi_slave dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .gpu_rd_addr(gpu_rd_addr), .gpu_rd_data(gpu_rd_data)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic aw_handshake(input logic [11:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [0:0] id);
      int n;
      AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
      n = 0;
      while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) begin n_total++; $display("FAIL aw_timeout: AWREADY got %b want 1", AWREADY); end
      tick();
      AWVALID = 1'b0;
   endtask

   task automatic axi_write(input logic [11:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb, input logic [0:0] id);
      int n;
      aw_handshake(addr, len, burst, id);
      for (int i = 0; i <= int'(len); i++) begin
         WDATA = wr_data[i]; WSTRB = strb; WLAST = (i == int'(len)); WVALID = 1'b1;
         n = 0;
         while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
         if (n >= 50) begin n_total++; $display("FAIL w_timeout: WREADY got %b want 1", WREADY); end
         tick();
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      n = 0;
      while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) begin n_total++; $display("FAIL b_timeout: BVALID got %b want 1", BVALID); end
      last_bresp = BRESP;
      last_bid = BID;
      tick();
      BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [0:0] id);
      int n;
      ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
      n = 0;
      while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) begin n_total++; $display("FAIL ar_timeout: ARREADY got %b want 1", ARREADY); end
      tick();
      ARVALID = 1'b0;
      first_rvalid = RVALID;
      last_rid = RID;
      RREADY = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         n = 0;
         while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
         if (n >= 50) begin n_total++; $display("FAIL r_timeout: RVALID got %b want 1", RVALID); end
         rd_data[i] = RDATA; rd_last[i] = RLAST; rd_resp[i] = RRESP;
         tick();
      end
      RREADY = 1'b0;
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      repeat (3) tick();
      n_total++;
      if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0)
         $display("FAIL reset_handshake: got %b want 000000", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
      else n_pass++;
      n_total++;
      if ({RDATA, gpu_rd_data, BID, RID, BRESP, RRESP} !== '0)
         $display("FAIL reset_data: RDATA %h gpu %h BID %b RID %b want all 0", RDATA, gpu_rd_data, BID, RID);
      else n_pass++;
      ARESETN = 1'b1;
      n_total++;
      if (AWREADY !== 1'b0) $display("FAIL reset_release_awready: got %b want 0", AWREADY);
      else n_pass++;
      tick();
      n_total++;
      if ({AWREADY, ARREADY} !== 2'b11) $display("FAIL post_reset_ready: got %b want 11", {AWREADY, ARREADY});
      else n_pass++;
   endtask

   task automatic test_incr();
      logic [7:0] lasts;
      for (int i = 0; i < 8; i++) wr_data[i] = 32'(i + 1);
      axi_write(12'h000, 8'd7, BURST_INCR, 4'hF, 1'b1);
      n_total++;
      if (last_bresp !== RESP_OKAY) $display("FAIL incr_bresp: got %b want 00", last_bresp);
      else n_pass++;
      n_total++;
      if (last_bid !== 1'b1) $display("FAIL incr_bid: got %b want 1", last_bid);
      else n_pass++;
      axi_read(12'h000, 8'd7, BURST_INCR, 1'b1);
      n_total++;
      if (first_rvalid !== 1'b1) $display("FAIL incr_rvalid_latency: got %b want 1", first_rvalid);
      else n_pass++;
      n_total++;
      if (last_rid !== 1'b1) $display("FAIL incr_rid: got %b want 1", last_rid);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (rd_data[i] !== 32'(i + 1)) $display("FAIL incr_data[%0d]: got %h want %h", i, rd_data[i], i + 1);
         else n_pass++;
         lasts[i] = rd_last[i];
      end
      n_total++;
      if (lasts !== 8'b1000_0000) $display("FAIL incr_rlast: got %b want 10000000", lasts);
      else n_pass++;
      n_total++;
      if ({rd_resp[0], rd_resp[7]} !== 4'b0) $display("FAIL incr_rresp: got %b %b want 00 00", rd_resp[0], rd_resp[7]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] hold;
      logic [31:0] got [8];
      int n;
      ARID = 1'b0; ARADDR = 12'h000; ARLEN = 8'd7; ARBURST = BURST_INCR; ARVALID = 1'b1;
      n = 0;
      while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
      tick();
      ARVALID = 1'b0;
      RREADY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            RREADY = 1'b0;
            hold = RDATA;
            for (int k = 0; k < 3; k++) begin
               tick();
               n_total++;
               if (RVALID !== 1'b1 || RDATA !== hold)
                  $display("FAIL stall_hold[%0d]: RVALID %b RDATA %h want 1 %h", k, RVALID, RDATA, hold);
               else n_pass++;
            end
            RREADY = 1'b1;
         end
         got[i] = RDATA;
         tick();
      end
      RREADY = 1'b0;
      n_total++;
      if ({got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]} !==
          {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8})
         $display("FAIL stall_order: got %h %h %h %h %h %h %h %h want 1..8",
                  got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]);
      else n_pass++;
      n_total++;
      if (RVALID !== 1'b0) $display("FAIL stall_end_rvalid: got %b want 0", RVALID);
      else n_pass++;
   endtask

   task automatic test_wrap();
      wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC; wr_data[3] = 32'hD;
      axi_write(12'h018, 8'd3, BURST_WRAP, 4'hF, 1'b0);
      axi_read(12'h010, 8'd3, BURST_INCR, 1'b0);
      n_total++;
      if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'hC, 32'hD, 32'hA, 32'hB})
         $display("FAIL wrap_data: got %h %h %h %h want c d a b", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
      else n_pass++;
      gpu_rd_addr = 8'd6;
      tick();
      n_total++;
      if (gpu_rd_data !== 32'hA) $display("FAIL wrap_gpu_word6: got %h want 0000000a", gpu_rd_data);
      else n_pass++;
   endtask

   task automatic test_strobe();
      wr_data[0] = 32'hFFFF_FFFF;
      axi_write(12'h020, 8'd0, BURST_INCR, 4'hF, 1'b0);
      wr_data[0] = 32'hAAAA_5555;
      axi_write(12'h020, 8'd0, BURST_INCR, 4'b0011, 1'b0);
      axi_read(12'h020, 8'd0, BURST_INCR, 1'b0);
      n_total++;
      if (rd_data[0] !== 32'hFFFF_5555) $display("FAIL strobe: got %h want ffff5555", rd_data[0]);
      else n_pass++;
   endtask

   task automatic test_fixed();
      wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33;
      axi_write(12'h040, 8'd2, BURST_FIXED, 4'hF, 1'b0);
      axi_read(12'h040, 8'd2, BURST_FIXED, 1'b0);
      n_total++;
      if ({rd_data[0], rd_data[1], rd_data[2]} !== {32'h33, 32'h33, 32'h33})
         $display("FAIL fixed_data: got %h %h %h want 33 33 33", rd_data[0], rd_data[1], rd_data[2]);
      else n_pass++;
      n_total++;
      if ({rd_last[0], rd_last[1], rd_last[2]} !== 3'b001)
         $display("FAIL fixed_rlast: got %b want 001", {rd_last[0], rd_last[1], rd_last[2]});
      else n_pass++;
      axi_read(12'h040, 8'd0, BURST_INCR, 1'b0);
      n_total++;
      if (rd_last[0] !== 1'b1) $display("FAIL single_beat_rlast: got %b want 1", rd_last[0]);
      else n_pass++;
   endtask

   task automatic test_gpu_port();
      int n;
      wr_data[0] = 32'h0;
      axi_write(12'h030, 8'd0, BURST_INCR, 4'hF, 1'b0);
      gpu_rd_addr = 8'd12;
      aw_handshake(12'h030, 8'd0, BURST_INCR, 1'b0);
      WDATA = 32'h1234_5678; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
      tick();
      WVALID = 1'b0; WLAST = 1'b0;
      n_total++;
      if (gpu_rd_data !== 32'h0) $display("FAIL gpu_same_cycle_old: got %h want 00000000", gpu_rd_data);
      else n_pass++;
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      n_total++;
      if (gpu_rd_data !== 32'h1234_5678) $display("FAIL gpu_next_cycle_new: got %h want 12345678", gpu_rd_data);
      else n_pass++;
   endtask

   task automatic test_slverr();
      wr_data[0] = 32'hDEAD_BEEF;
      axi_write(12'h400, 8'd0, BURST_INCR, 4'hF, 1'b0);
      axi_read(12'h400, 8'd0, BURST_INCR, 1'b0);
`ifdef GPU_BLOCK_AXI_SLVERR_EN
      n_total++;
      if (last_bresp !== RESP_SLVERR) $display("FAIL oor_bresp: got %b want 10", last_bresp);
      else n_pass++;
      n_total++;
      if (rd_data[0] !== 32'h0 || rd_resp[0] !== RESP_SLVERR)
         $display("FAIL oor_read: got %h/%b want 00000000/10", rd_data[0], rd_resp[0]);
      else n_pass++;
      axi_read(12'h000, 8'd0, BURST_INCR, 1'b0);
      n_total++;
      if (rd_data[0] !== 32'h1 || rd_resp[0] !== RESP_OKAY)
         $display("FAIL oor_word0_kept: got %h/%b want 00000001/00", rd_data[0], rd_resp[0]);
      else n_pass++;
`else
      n_total++;
      if (last_bresp !== RESP_OKAY) $display("FAIL alias_bresp: got %b want 00", last_bresp);
      else n_pass++;
      n_total++;
      if (rd_data[0] !== 32'hDEAD_BEEF || rd_resp[0] !== RESP_OKAY)
         $display("FAIL alias_read: got %h/%b want deadbeef/00", rd_data[0], rd_resp[0]);
      else n_pass++;
      axi_read(12'h000, 8'd0, BURST_INCR, 1'b0);
      n_total++;
      if (rd_data[0] !== 32'hDEAD_BEEF) $display("FAIL alias_word0: got %h want deadbeef", rd_data[0]);
      else n_pass++;
`endif
   endtask

   task automatic test_incr_top();
      wr_data[0] = 32'h55; wr_data[1] = 32'h66;
      axi_write(12'h3FC, 8'd1, BURST_INCR, 4'hF, 1'b0);
      axi_read(12'h3FC, 8'd1, BURST_INCR, 1'b0);
      n_total++;
      if (rd_data[0] !== 32'h55) $display("FAIL top_beat0: got %h want 00000055", rd_data[0]);
      else n_pass++;
`ifdef GPU_BLOCK_AXI_SLVERR_EN
      n_total++;
      if (last_bresp !== RESP_SLVERR || rd_data[1] !== 32'h0 || rd_resp[1] !== RESP_SLVERR)
         $display("FAIL top_beat1_oor: bresp %b data %h rresp %b want 10 00000000 10", last_bresp, rd_data[1], rd_resp[1]);
      else n_pass++;
`else
      axi_read(12'h000, 8'd0, BURST_INCR, 1'b0);
      n_total++;
      if (rd_data[0] !== 32'h66) $display("FAIL top_wrap_word0: got %h want 00000066", rd_data[0]);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      int  n;
      logic bseen;
      for (int i = 0; i < 8; i++) wr_data[i] = 32'h100 + 32'(i);
      aw_handshake(12'h100, 8'd7, BURST_INCR, 1'b1);
      for (int i = 0; i < 2; i++) begin
         WDATA = wr_data[i]; WSTRB = 4'hF; WVALID = 1'b1;
         n = 0;
         while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
         tick();
      end
      WDATA = wr_data[2];
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      WVALID = 1'b0;
      n_total++;
      if ({BVALID, AWREADY} !== 2'b00) $display("FAIL midreset_outputs: BVALID/AWREADY got %b want 00", {BVALID, AWREADY});
      else n_pass++;
      tick();
      n_total++;
      if (AWREADY !== 1'b1) $display("FAIL midreset_awready: got %b want 1", AWREADY);
      else n_pass++;
      bseen = 1'b0;
      BREADY = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (BVALID !== 1'b0) bseen = 1'b1;
         tick();
      end
      BREADY = 1'b0;
      n_total++;
      if (bseen !== 1'b0) $display("FAIL midreset_no_bresp: BVALID seen %b want 0", bseen);
      else n_pass++;
      axi_read(12'h100, 8'd1, BURST_INCR, 1'b0);
      n_total++;
      if ({rd_data[0], rd_data[1]} !== {32'h100, 32'h101})
         $display("FAIL midreset_retained: got %h %h want 00000100 00000101", rd_data[0], rd_data[1]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_incr();
      test_backpressure();
      test_wrap();
      test_strobe();
      test_fixed();
      test_gpu_port();
      test_slverr();
      test_incr_top();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
